// File: rtl/rand_coord_gen.sv
// rand_coord_gen: draws a random (x, y) coordinate pair by rejection sampling
// two independent Fibonacci LFSRs against X_RANGE / Y_RANGE. The draw can
// reject one forbidden cell (avoid_x, avoid_y). If MAX_TRIES draw cycles pass
// without a pair, each unaccepted axis falls back to v mod RANGE.
// The pair is held on out_x/out_y with out_valid until out_ready.
//
// Optional feature: define RAND_COORD_SEED_LOAD_EN to add the seed_load,
// seed_x and seed_y inputs, which reseed both LFSRs at run time.

module rand_coord_gen #(
    parameter int               WIDTH     = 4,
    parameter int               X_RANGE   = 10,
    parameter int               Y_RANGE   = 10,
    parameter logic [WIDTH-1:0] X_SEED    = WIDTH'(4'b0011),
    parameter logic [WIDTH-1:0] Y_SEED    = WIDTH'(4'b1011),
    parameter int               MAX_TRIES = 16,
    parameter int               COORD_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef RAND_COORD_SEED_LOAD_EN
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_x,
    input  logic [WIDTH-1:0]   seed_y,
`endif
    input  logic               req,
    input  logic               out_ready,
    input  logic               avoid_en,
    input  logic [COORD_W-1:0] avoid_x,
    input  logic [COORD_W-1:0] avoid_y,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               busy
);

    // The try counter only has to reach MAX_TRIES-1; it needs at least one bit.
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    // Maximal-length tap sets, zero-indexed bit masks for widths 4..8.
    localparam logic [7:0] TAP_MASK8 = (WIDTH == 4) ? 8'h0C :
                                       (WIDTH == 5) ? 8'h14 :
                                       (WIDTH == 6) ? 8'h30 :
                                       (WIDTH == 7) ? 8'h60 : 8'hB8;
    localparam logic [WIDTH-1:0] TAPS = TAP_MASK8[WIDTH-1:0];

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] X_SEED_EFF = (X_SEED == {WIDTH{1'b0}}) ? SEED_ONE : X_SEED;
    localparam logic [WIDTH-1:0] Y_SEED_EFF = (Y_SEED == {WIDTH{1'b0}}) ? SEED_ONE : Y_SEED;

    // Ranges widened by one bit so a range of exactly 2^WIDTH is representable.
    localparam logic [WIDTH:0]   X_RANGE_V = (WIDTH + 1)'(X_RANGE);
    localparam logic [WIDTH:0]   Y_RANGE_V = (WIDTH + 1)'(Y_RANGE);
    localparam logic [COORD_W:0] X_RANGE_C = (COORD_W + 1)'(X_RANGE);
    localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shift left, XOR of the tap bits enters at the LSB.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    // Fold an out-of-range LFSR value into 0..range-1 for the fallback path.
    function automatic logic [COORD_W-1:0] fold_range(input logic [WIDTH-1:0] v,
                                                      input logic [WIDTH:0]   range);
        logic [WIDTH:0] rem;
        rem = {1'b0, v} % range;
        return COORD_W'(rem);
    endfunction

`ifdef RAND_COORD_SEED_LOAD_EN
    // Run-time seeds get the same zero protection as the reset seeds.
    function automatic logic [WIDTH-1:0] nz_seed(input logic [WIDTH-1:0] s);
        return (s == {WIDTH{1'b0}}) ? SEED_ONE : s;
    endfunction
`endif

    state_t             state_r;
    logic [WIDTH-1:0]   lfsr_x_r;
    logic [WIDTH-1:0]   lfsr_y_r;
    logic [TRY_W-1:0]   try_r;
    logic               acc_x_r;
    logic               acc_y_r;
    logic [COORD_W-1:0] out_x_r;
    logic [COORD_W-1:0] out_y_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               last_try_s;
    logic [COORD_W-1:0] cand_x_s;
    logic [COORD_W-1:0] cand_y_s;
    logic               cand_hx_s;
    logic               cand_hy_s;
    logic               pair_full_s;
    logic               pair_hit_s;
    logic [COORD_W:0]   bump_w_s;
    logic [COORD_W-1:0] bump_x_s;

    assign out_valid = out_valid_r;
    assign out_x     = out_x_r;
    assign out_y     = out_y_r;
    assign busy      = busy_r;

    // Free-running LFSRs: step on every non-reset edge regardless of FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_x_r <= X_SEED_EFF;
            lfsr_y_r <= Y_SEED_EFF;
        end
`ifdef RAND_COORD_SEED_LOAD_EN
        else if (seed_load) begin
            lfsr_x_r <= nz_seed(seed_x);
            lfsr_y_r <= nz_seed(seed_y);
        end
`endif
        else begin
            lfsr_x_r <= lfsr_next(lfsr_x_r);
            lfsr_y_r <= lfsr_next(lfsr_y_r);
        end
    end

    // Candidate pair for this draw edge: accepted axes keep their latched value,
    // others accept an in-range LFSR value or, on the last try, fold it.
    always_comb begin
        last_try_s = (try_r == LAST_TRY);
        cand_x_s   = out_x_r;
        cand_hx_s  = acc_x_r;
        cand_y_s   = out_y_r;
        cand_hy_s  = acc_y_r;

        if (acc_x_r) begin
            cand_x_s  = out_x_r;
            cand_hx_s = 1'b1;
        end else if (last_try_s) begin
            cand_x_s  = fold_range(lfsr_x_r, X_RANGE_V);
            cand_hx_s = 1'b1;
        end else if ({1'b0, lfsr_x_r} < X_RANGE_V) begin
            cand_x_s  = COORD_W'(lfsr_x_r);
            cand_hx_s = 1'b1;
        end else begin
            cand_x_s  = out_x_r;
            cand_hx_s = 1'b0;
        end

        if (acc_y_r) begin
            cand_y_s  = out_y_r;
            cand_hy_s = 1'b1;
        end else if (last_try_s) begin
            cand_y_s  = fold_range(lfsr_y_r, Y_RANGE_V);
            cand_hy_s = 1'b1;
        end else if ({1'b0, lfsr_y_r} < Y_RANGE_V) begin
            cand_y_s  = COORD_W'(lfsr_y_r);
            cand_hy_s = 1'b1;
        end else begin
            cand_y_s  = out_y_r;
            cand_hy_s = 1'b0;
        end

        pair_full_s = cand_hx_s & cand_hy_s;
        pair_hit_s  = avoid_en & (cand_x_s == avoid_x) & (cand_y_s == avoid_y);

        // Fallback escape from the forbidden cell: step x by one, wrapping.
        bump_w_s = ({1'b0, avoid_x} + {{COORD_W{1'b0}}, 1'b1}) % X_RANGE_C;
        bump_x_s = bump_w_s[COORD_W-1:0];
    end

    // Draw FSM with registered out_valid/busy and the held coordinate pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            try_r       <= {TRY_W{1'b0}};
            acc_x_r     <= 1'b0;
            acc_y_r     <= 1'b0;
            out_x_r     <= {COORD_W{1'b0}};
            out_y_r     <= {COORD_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end
`ifdef RAND_COORD_SEED_LOAD_EN
        else if (seed_load) begin
            state_r     <= ST_IDLE;
            try_r       <= {TRY_W{1'b0}};
            acc_x_r     <= 1'b0;
            acc_y_r     <= 1'b0;
            out_x_r     <= {COORD_W{1'b0}};
            out_y_r     <= {COORD_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end
`endif
        else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        state_r <= ST_DRAW;
                        busy_r  <= 1'b1;
                        try_r   <= {TRY_W{1'b0}};
                        acc_x_r <= 1'b0;
                        acc_y_r <= 1'b0;
                    end
                end

                ST_DRAW: begin
                    try_r   <= try_r + TRY_W'(1);
                    out_y_r <= cand_y_s;
                    if (last_try_s) begin
                        // Out of tries: finish with whatever was drawn.
                        out_x_r     <= pair_hit_s ? bump_x_s : cand_x_s;
                        acc_x_r     <= 1'b1;
                        acc_y_r     <= 1'b1;
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (pair_full_s && !pair_hit_s) begin
                        out_x_r     <= cand_x_s;
                        acc_x_r     <= 1'b1;
                        acc_y_r     <= 1'b1;
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (pair_full_s) begin
                        // Completed pair is the forbidden cell: redraw both axes.
                        out_x_r <= cand_x_s;
                        acc_x_r <= 1'b0;
                        acc_y_r <= 1'b0;
                    end else begin
                        out_x_r <= cand_x_s;
                        acc_x_r <= cand_hx_s;
                        acc_y_r <= cand_hy_s;
                    end
                end

                ST_DONE: begin
                    // out_ready is only looked at here, so a ready asserted on
                    // the DRAW->DONE edge cannot drop the pair early.
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_coord_gen.sv
// Bench for rand_coord_gen: three parameterisations share one stimulus stream
// and are checked every cycle against an integer-arithmetic reference model.
module tb_rand_coord_gen;

    logic       clk;
    logic       reset;
    logic       req;
    logic       out_ready;
    logic       avoid_en;
    logic [3:0] avoid_x;
    logic [3:0] avoid_y;

    logic [2:0]      vld;
    logic [2:0]      bsy;
    logic [2:0][3:0] ox;
    logic [2:0][3:0] oy;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance configuration: 0 = defaults, 1 = X_SEED 0110,
    // 2 = X_RANGE 2 / Y_RANGE 16 / MAX_TRIES 1 / zero Y_SEED.
    int cfg_xr [3] = '{10, 10, 2};
    int cfg_yr [3] = '{10, 10, 16};
    int cfg_mt [3] = '{16, 16, 1};
    int cfg_sx [3] = '{3, 6, 3};
    int cfg_sy [3] = '{11, 11, 1};

    // Model: phase 0 idle, 1 drawing, 2 holding a pair.
    int m_lx [3];
    int m_ly [3];
    int m_ph [3];
    int m_tr [3];
    int m_hx [3];
    int m_hy [3];
    int m_ox [3];
    int m_oy [3];

    rand_coord_gen u_a (
        .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
        .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y),
        .out_valid(vld[0]), .out_x(ox[0]), .out_y(oy[0]), .busy(bsy[0])
    );

    rand_coord_gen #(.X_SEED(4'b0110)) u_b (
        .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
        .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y),
        .out_valid(vld[1]), .out_x(ox[1]), .out_y(oy[1]), .busy(bsy[1])
    );

    rand_coord_gen #(.X_RANGE(2), .Y_RANGE(16), .MAX_TRIES(1), .Y_SEED(4'b0000)) u_c (
        .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
        .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y),
        .out_valid(vld[2]), .out_x(ox[2]), .out_y(oy[2]), .busy(bsy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 4-bit maximal LFSR with taps 3 and 2, shifting left.
    function automatic int lfsr4(input int v);
        int fb;
        fb = ((v >> 3) ^ (v >> 2)) & 1;
        return ((v << 1) & 15) | fb;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs applied for it.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int vx, vy, nx, ny, nhx, nhy, last, hit;
            vx = m_lx[i];
            vy = m_ly[i];
            if (reset) begin
                m_lx[i] = cfg_sx[i];
                m_ly[i] = cfg_sy[i];
                m_ph[i] = 0; m_tr[i] = 0; m_hx[i] = 0; m_hy[i] = 0;
                m_ox[i] = 0; m_oy[i] = 0;
            end else begin
                if (m_ph[i] == 0) begin
                    if (req) begin
                        m_ph[i] = 1; m_tr[i] = 0; m_hx[i] = 0; m_hy[i] = 0;
                    end
                end else if (m_ph[i] == 1) begin
                    nx = m_ox[i]; ny = m_oy[i]; nhx = m_hx[i]; nhy = m_hy[i];
                    last = (m_tr[i] == cfg_mt[i] - 1);
                    if (!nhx) begin
                        if (last) begin nx = vx % cfg_xr[i]; nhx = 1; end
                        else if (vx < cfg_xr[i]) begin nx = vx; nhx = 1; end
                    end
                    if (!nhy) begin
                        if (last) begin ny = vy % cfg_yr[i]; nhy = 1; end
                        else if (vy < cfg_yr[i]) begin ny = vy; nhy = 1; end
                    end
                    hit = avoid_en && (nx == int'(avoid_x)) && (ny == int'(avoid_y));
                    if (last) begin
                        if (hit) nx = (int'(avoid_x) + 1) % cfg_xr[i];
                        m_ph[i] = 2;
                    end else if (nhx && nhy) begin
                        if (hit) begin nhx = 0; nhy = 0; end
                        else m_ph[i] = 2;
                    end
                    m_ox[i] = nx; m_oy[i] = ny; m_hx[i] = nhx; m_hy[i] = nhy;
                    m_tr[i] = m_tr[i] + 1;
                end else begin
                    if (out_ready) m_ph[i] = 0;
                end
                m_lx[i] = lfsr4(vx);
                m_ly[i] = lfsr4(vy);
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("inst%0d out_valid", i), int'(vld[i]), int'(m_ph[i] == 2));
            check($sformatf("inst%0d busy", i), int'(bsy[i]), int'(m_ph[i] == 1));
            if (m_ph[i] == 2) begin
                check($sformatf("inst%0d out_x", i), int'(ox[i]), m_ox[i]);
                check($sformatf("inst%0d out_y", i), int'(oy[i]), m_oy[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; out_ready = 1'b0; avoid_en = 1'b0;
        avoid_x = 4'd0; avoid_y = 4'd0;
        @(negedge clk);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset inst%0d valid", i), int'(vld[i]), 0);
            check($sformatf("reset inst%0d busy", i), int'(bsy[i]), 0);
            check($sformatf("reset inst%0d x", i), int'(ox[i]), 0);
            check($sformatf("reset inst%0d y", i), int'(oy[i]), 0);
        end

        // Basic draws with req held and consumer stalled.
        reset = 1'b0; req = 1'b1;
        tick();
        check("A edge1 busy", int'(bsy[0]), 1);
        check("A edge1 valid", int'(vld[0]), 0);
        tick();
        check("A edge2 valid", int'(vld[0]), 1);
        check("A edge2 x", int'(ox[0]), 6);
        check("A edge2 y", int'(oy[0]), 7);
        check("model A x", m_ox[0], 6);
        check("C fallback valid", int'(vld[2]), 1);
        check("C fallback x", int'(ox[2]), 0);
        check("C fallback y", int'(oy[2]), 2);
        check("B edge2 busy", int'(bsy[1]), 1);
        tick();
        check("B edge3 valid", int'(vld[1]), 0);
        tick();
        check("B edge4 valid", int'(vld[1]), 1);
        check("B edge4 x", int'(ox[1]), 5);
        check("B edge4 y", int'(oy[1]), 7);
        check("model B x", m_ox[1], 5);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("A hold valid", int'(vld[0]), 1);
            check("A hold x", int'(ox[0]), 6);
            check("A hold y", int'(oy[0]), 7);
        end
        req = 1'b0; out_ready = 1'b1;
        tick();
        check("A release valid", int'(vld[0]), 0);
        check("A release busy", int'(bsy[0]), 0);

        // Reset in the middle of a draw.
        out_ready = 1'b0; req = 1'b1;
        tick();
        check("B draw busy", int'(bsy[1]), 1);
        reset = 1'b1; req = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort inst%0d valid", i), int'(vld[i]), 0);
            check($sformatf("abort inst%0d busy", i), int'(bsy[i]), 0);
        end

        // Avoid cell (6,7) from fresh seeds: first pair rejected, (5,8) after edge 6.
        reset = 1'b0; req = 1'b1; avoid_en = 1'b1; avoid_x = 4'd6; avoid_y = 4'd7;
        tick();
        tick();
        check("avoid edge2 valid", int'(vld[0]), 0);
        check("avoid edge2 busy", int'(bsy[0]), 1);
        tick();
        tick();
        tick();
        check("avoid edge5 valid", int'(vld[0]), 0);
        tick();
        check("avoid edge6 valid", int'(vld[0]), 1);
        check("avoid edge6 x", int'(ox[0]), 5);
        check("avoid edge6 y", int'(oy[0]), 8);
        check("model avoid y", m_oy[0], 8);
        req = 1'b0; out_ready = 1'b1; avoid_en = 1'b0;
        tick();

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) == 0);
            avoid_en  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                avoid_x = 4'd6;
                avoid_y = 4'd7;
            end else begin
                avoid_x = 4'($urandom_range(0, 15));
                avoid_y = 4'($urandom_range(0, 15));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
